// File: rtl/washer_bank_arbiter_if.sv
// rtl/washer_bank_arbiter_if.sv - request/grant bundle between washer controllers and the bank arbiter
interface washer_bank_arbiter_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic [N-1:0] fill_req;
    logic [N-1:0] drain_req;
    logic [N-1:0] fill_gnt;
    logic [N-1:0] drain_gnt;
    logic         valve_open;
    logic         pump_on;
    logic [W-1:0] fill_owner;
    logic [W-1:0] drain_owner;
    logic         fill_timeout;
    logic         drain_timeout;

    // washer controller side
    modport master (
        output fill_req, drain_req,
        input  fill_gnt, drain_gnt, valve_open, pump_on,
        input  fill_owner, drain_owner, fill_timeout, drain_timeout
    );

    // arbiter side
    modport slave (
        input  fill_req, drain_req,
        output fill_gnt, drain_gnt, valve_open, pump_on,
        output fill_owner, drain_owner, fill_timeout, drain_timeout
    );
endinterface

// File: rtl/washer_bank_arbiter.sv
// rtl/washer_bank_arbiter.sv - round-robin arbiter with hold limit for shared inlet valve and drain pump
module washer_bank_channel #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 1000,
    parameter int SETTLE   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 timeout
);
    localparam int W  = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int SW = $clog2(SETTLE + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    localparam logic [HW-1:0] HOLD_LIM   = HW'(MAX_HOLD);
    localparam logic [SW-1:0] SETTLE_LIM = SW'(SETTLE);

    logic [1:0]    state;
    logic [W-1:0]  ptr;
    logic [HW-1:0] hold;
    logic [SW-1:0] settle;
    logic [HW-1:0] hold_next;
    logic [SW-1:0] settle_next;
    logic [W-1:0]  winner;
    logic          found;

    assign hold_next   = hold + HW'(1);
    assign settle_next = settle + SW'(1);

    // pick the first requester at or after the rotation pointer, wrapping
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found  = 1'b1;
                winner = W'((int'(ptr) + i) % N);
            end
        end
    end

    // channel FSM: arbitrate in IDLE, hold up to MAX_HOLD in GRANT, dead time in SETTLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            owner   <= '0;
            hold    <= '0;
            settle  <= '0;
            gnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt   <= {{(N-1){1'b0}}, 1'b1} << winner;
                        owner <= winner;
                        hold  <= '0;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    hold <= hold_next;
                    if (!req[owner] || hold_next == HOLD_LIM) begin
                        gnt     <= '0;
                        ptr     <= (owner == W'(N - 1)) ? '0 : owner + W'(1);
                        // a dropped request wins over the hold limit: no timeout then
                        timeout <= req[owner];
                        settle  <= '0;
                        state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_next == SETTLE_LIM) begin
                        settle <= '0;
                        state  <= S_IDLE;
                    end else begin
                        settle <= settle_next;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

module washer_bank_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 1000,
    parameter int SETTLE   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    washer_bank_arbiter_if.slave  bus
);
    washer_bank_channel #(.N(N), .MAX_HOLD(MAX_HOLD), .SETTLE(SETTLE)) u_fill (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.fill_req),
        .gnt     (bus.fill_gnt),
        .owner   (bus.fill_owner),
        .timeout (bus.fill_timeout)
    );

    washer_bank_channel #(.N(N), .MAX_HOLD(MAX_HOLD), .SETTLE(SETTLE)) u_drain (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.drain_req),
        .gnt     (bus.drain_gnt),
        .owner   (bus.drain_owner),
        .timeout (bus.drain_timeout)
    );

    // shared drives come only from registered grants, so they cannot glitch
    assign bus.valve_open = |bus.fill_gnt;
    assign bus.pump_on    = |bus.drain_gnt;
endmodule

// File: tb/tb_washer_bank_arbiter.sv
// tb/tb_washer_bank_arbiter.sv - scoreboard bench for washer_bank_arbiter
module tb_washer_bank_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    washer_bank_arbiter_if #(.N(4)) bus ();

    washer_bank_arbiter #(.N(4), .MAX_HOLD(5), .SETTLE(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int washer;
        int len;
        int tmo;
        int gap;
    } exp_t;

    exp_t q_fill[$];
    exp_t q_drain[$];

    int checks = 0;
    int errors = 0;

    int         m_len[2]  = '{0, 0};
    int         m_low[2]  = '{0, 0};
    int         m_gap[2]  = '{0, 0};
    int         m_wash[2] = '{0, 0};
    logic [3:0] m_prev[2] = '{4'd0, 4'd0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int ch, input int washer, input int len, input int tmo, input int gap);
        exp_t e;
        e.washer = washer;
        e.len    = len;
        e.tmo    = tmo;
        e.gap    = gap;
        if (ch == 0) q_fill.push_back(e);
        else         q_drain.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task mon(input int ch, input logic [3:0] g, input logic [1:0] own, input logic tmo, input logic drv);
        exp_t  e;
        string cn;
        bit    have;
        cn = (ch == 0) ? "fill" : "drain";
        if (g != 4'd0) begin
            if (m_prev[ch] == 4'd0) begin
                chk({cn, "_onehot"}, $countones(g), 1);
                m_wash[ch] = $clog2(g);
                chk({cn, "_owner_start"}, int'(own), m_wash[ch]);
                m_gap[ch] = m_low[ch];
                m_len[ch] = 0;
            end
            m_len[ch]++;
            chk({cn, "_tmo_in_grant"}, int'(tmo), 0);
            chk({cn, "_drive_on"}, int'(drv), 1);
        end else begin
            if (m_prev[ch] != 4'd0) begin
                have = (ch == 0) ? (q_fill.size() != 0) : (q_drain.size() != 0);
                if (!have) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_unexpected_grant actual=%0d expected=none", cn, m_wash[ch]);
                end else begin
                    if (ch == 0) e = q_fill.pop_front();
                    else         e = q_drain.pop_front();
                    chk({cn, "_washer"}, m_wash[ch], e.washer);
                    chk({cn, "_owner_hold"}, int'(own), e.washer);
                    chk({cn, "_len"}, m_len[ch], e.len);
                    chk({cn, "_timeout"}, int'(tmo), e.tmo);
                    if (e.gap >= 0) chk({cn, "_gap"}, m_gap[ch], e.gap);
                end
                m_low[ch] = 1;
            end else begin
                m_low[ch]++;
                chk({cn, "_tmo_spurious"}, int'(tmo), 0);
            end
            chk({cn, "_drive_off"}, int'(drv), 0);
        end
        m_prev[ch] = g;
    endtask

    // monitor: sample away from the active edge, pop expectations at each grant end
    always @(negedge clk) begin
        if (reset) begin
            m_prev = '{4'd0, 4'd0};
            m_low  = '{0, 0};
        end else begin
            mon(0, bus.fill_gnt, bus.fill_owner, bus.fill_timeout, bus.valve_open);
            mon(1, bus.drain_gnt, bus.drain_owner, bus.drain_timeout, bus.pump_on);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        order = '{1, 2, 3, 0, 1};
        bus.fill_req  = 4'b0000;
        bus.drain_req = 4'b0000;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;

        chk("rst_fill_gnt", int'(bus.fill_gnt), 0);
        chk("rst_drain_gnt", int'(bus.drain_gnt), 0);
        chk("rst_valve", int'(bus.valve_open), 0);
        chk("rst_pump", int'(bus.pump_on), 0);
        chk("rst_fill_owner", int'(bus.fill_owner), 0);
        chk("rst_drain_owner", int'(bus.drain_owner), 0);
        chk("rst_fill_tmo", int'(bus.fill_timeout), 0);
        chk("rst_drain_tmo", int'(bus.drain_timeout), 0);

        // single request, latency one edge, released after 2 cycles
        push(0, 0, 2, 0, -1);
        bus.fill_req = 4'b0001;
        tick(1);
        chk("lat_fill_gnt", int'(bus.fill_gnt), 1);
        chk("lat_valve", int'(bus.valve_open), 1);
        chk("lat_fill_owner", int'(bus.fill_owner), 0);
        tick(1);
        bus.fill_req = 4'b0000;
        tick(4);

        // all four requesting: rotation from ptr 1, each revoked by the hold limit
        for (int i = 0; i < 5; i++) push(0, order[i], 5, 1, (i == 0) ? -1 : 3);
        bus.fill_req = 4'b1111;
        tick(1);
        tick(37);
        bus.fill_req = 4'b0000;
        tick(4);

        // washer 2 releases early, next winner scans from 3
        push(0, 2, 3, 0, -1);
        push(0, 3, 1, 0, 3);
        bus.fill_req = 4'b1101;
        tick(1);
        tick(2);
        bus.fill_req = 4'b1001;
        tick(4);
        bus.fill_req = 4'b0000;
        tick(4);

        // request drops on the edge the hold count reaches the limit: no timeout
        push(0, 0, 5, 0, -1);
        bus.fill_req = 4'b0001;
        tick(1);
        tick(4);
        bus.fill_req = 4'b0000;
        tick(4);

        // channel independence: fill to washer 1, drain to washer 3
        push(0, 1, 3, 0, -1);
        push(1, 3, 1, 0, -1);
        bus.fill_req = 4'b0010;
        tick(1);
        bus.drain_req = 4'b1000;
        tick(1);
        chk("ind_drain_gnt", int'(bus.drain_gnt), 8);
        chk("ind_pump", int'(bus.pump_on), 1);
        chk("ind_drain_owner", int'(bus.drain_owner), 3);
        chk("ind_fill_gnt", int'(bus.fill_gnt), 2);
        bus.drain_req = 4'b0000;
        tick(1);
        bus.fill_req = 4'b0000;
        tick(4);

        // both grants held by washer 1 at once
        push(0, 1, 5, 1, -1);
        push(1, 1, 2, 0, -1);
        bus.fill_req  = 4'b0010;
        bus.drain_req = 4'b0010;
        tick(1);
        chk("both_fill_gnt", int'(bus.fill_gnt), 2);
        chk("both_drain_gnt", int'(bus.drain_gnt), 2);
        tick(1);
        bus.drain_req = 4'b0000;
        tick(4);
        bus.fill_req = 4'b0000;
        tick(4);

        // asynchronous reset in the middle of a grant
        bus.fill_req  = 4'b1010;
        bus.drain_req = 4'b0100;
        tick(1);
        chk("pre_rst_fill_gnt", int'(bus.fill_gnt), 8);
        chk("pre_rst_drain_gnt", int'(bus.drain_gnt), 4);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_fill_gnt", int'(bus.fill_gnt), 0);
        chk("arst_drain_gnt", int'(bus.drain_gnt), 0);
        chk("arst_valve", int'(bus.valve_open), 0);
        chk("arst_pump", int'(bus.pump_on), 0);
        tick(1);
        reset = 1'b0;
        push(0, 1, 1, 0, -1);
        push(1, 2, 1, 0, -1);
        tick(1);
        chk("post_rst_fill_gnt", int'(bus.fill_gnt), 2);
        chk("post_rst_fill_owner", int'(bus.fill_owner), 1);
        chk("post_rst_drain_gnt", int'(bus.drain_gnt), 4);
        bus.fill_req  = 4'b0000;
        bus.drain_req = 4'b0000;
        tick(6);

        chk("fill_queue_left", q_fill.size(), 0);
        chk("drain_queue_left", q_drain.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/washer_bank_arbiter.md
# washer_bank_arbiter

Shares one building water inlet valve and one common drain pump among N washer controllers in a laundromat bank. Each washer controller raises a fill request when it wants Water and a drain request when it wants Pump. This block grants each shared resource to one washer at a time, using round-robin order with a maximum hold time. It sits above the per-washer controllers, and its grants gate their Water/Pump outputs onto the shared hardware.

## Interface
- N, default 4: number of washers, legal range 2..8.
- MAX_HOLD, default 1000: maximum consecutive grant cycles per channel, ≥1.
- SETTLE, default 2: valve/pump changeover dead cycles between grants, ≥1.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fill_req  in  N  per-washer request for the inlet valve; level, held while needed.
- drain_req  in  N  per-washer request for the drain pump; level.
- fill_gnt  out  N  one-hot or zero; washer i owns the valve.
- drain_gnt  out  N  one-hot or zero; washer i owns the pump.
- valve_open  out  1  shared inlet valve drive; equals |fill_gnt.
- pump_on  out  1  shared pump drive; equals |drain_gnt.
- fill_owner  out  $clog2(N)  index of current/last fill grantee.
- drain_owner  out  $clog2(N)  index of current/last drain grantee.
- fill_timeout  out  1  one-cycle pulse: fill grant revoked by MAX_HOLD.
- drain_timeout  out  1  one-cycle pulse: drain grant revoked by MAX_HOLD.

## Operation
- There are two identical, independent channels: fill and drain. Each channel has its own FSM, rotation pointer, hold counter and settle counter. The text below describes one channel (req, gnt, owner, timeout).
- Reset values: state IDLE, ptr 0, owner 0, all counters 0, all outputs 0.
- IDLE:
  - If req is nonzero, select winner as the first set bit scanning from ptr upward, wrapping modulo N.
  - Register gnt = onehot(winner) and owner = winner.
  - Clear the hold counter and go to GRANT.
- GRANT:
  - gnt stays asserted and the hold counter increments every cycle.
  - Release when req[owner] samples 0, or when the counter reaches MAX_HOLD.
  - On release: gnt goes to 0, ptr = (owner+1) mod N, and the FSM goes to SETTLE.
  - If release is due to MAX_HOLD only, pulse timeout for one cycle, coincident with gnt falling.
- SETTLE: gnt stays 0 for exactly SETTLE cycles, then the FSM goes to IDLE. Requests during SETTLE are ignored, not latched.
- Requests from non-owners during GRANT do not affect the grant.
- Simultaneous events:
  - If req[owner] drops in the same cycle the count reaches MAX_HOLD, it is a normal release with no timeout pulse.
  - If a winner's req drops in the cycle immediately after selection, it is still granted for exactly 1 cycle.
- A timed-out washer still requesting stays eligible. Rotation gives every other requester priority first.
- owner holds its last value through SETTLE and IDLE.
- Counter widths: hold counter $clog2(MAX_HOLD+1), settle counter $clog2(SETTLE+1). Neither counter may wrap.
- Reset mid-grant: gnt, valve_open and pump_on deassert asynchronously. The next grant after reset starts from washer 0.

## Timing
- Grant latency: req is sampled in IDLE at edge k, and gnt is high after edge k (visible in cycle k+1).
- Grant length: at most MAX_HOLD cycles.
- Release latency: req[owner] falls and is sampled at edge k; gnt is low after edge k.
- Minimum gap between grants on a channel: SETTLE cycles plus 1 IDLE arbitration cycle.
- Worst-case wait per requester: (N-1)·(MAX_HOLD+SETTLE+1) cycles.
- valve_open and pump_on are registered-equivalent; they are combinational only from registered gnt, so they are glitch-free.
- The fill and drain channels never interact. A washer may hold both grants simultaneously.

## Test plan
- Reset then idle: all outputs are 0. Assert fill_req=0001 → fill_gnt=0001 one cycle after sampling, valve_open=1, fill_owner=0.
- Rotation: N=4, fill_req=1111 held, MAX_HOLD=5, SETTLE=2 → grants go 0,1,2,3,0. Each is 5 cycles, with a timeout pulse at each revoke and 3 low cycles between grants.
- Early release: washer 2 granted, fill_req[2] drops after 3 cycles → gnt low next edge, no timeout, next winner is the first requester from index 3.
- Simultaneous drop at MAX_HOLD: req drops on the cycle the count hits 5 → release with fill_timeout=0.
- Independence: washer 1 holds fill while washer 3 requests drain → drain_gnt=1000 with latency 1, fill is unaffected. Both grants to washer 1 are also allowed.
- Async reset mid-GRANT: assert reset between edges → gnt, valve_open and pump_on go 0 immediately. After release with fill_req=1010, the first grant goes to washer 1.
